// File: rtl/donkey_ctl.sv
// donkey_ctl: turns left/right/jump requests into the Donkey sprite's top-left
// position, with saturating horizontal walking and a fixed-cadence jump arc.
module donkey_ctl #(
    parameter int JUMP_HEIGHT      = 58,
    parameter int JUMP_STEP_CYCLES = 1_400_000,
    parameter int MOVE_STEP_CYCLES = 250_000,
    parameter int CHAR_W           = 48,
    parameter int INIT_X           = 128,
    parameter int INIT_Y           = 672,
    parameter int X_MAX            = 1024 - CHAR_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        left,
    input  logic        right,
    input  logic        jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        airborne,
    output logic        facing_left
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_e;

    // Counters only need to reach STEP-1, so $clog2(STEP) bits suffice; keep at least one bit.
    localparam int MCW = (MOVE_STEP_CYCLES > 1) ? $clog2(MOVE_STEP_CYCLES) : 1;
    localparam int JCW = (JUMP_STEP_CYCLES > 1) ? $clog2(JUMP_STEP_CYCLES) : 1;
    localparam int HW  = (JUMP_HEIGHT > 0) ? $clog2(JUMP_HEIGHT + 1) : 1;

    localparam logic [MCW-1:0] MOVE_TERM  = MCW'(MOVE_STEP_CYCLES - 1);
    localparam logic [JCW-1:0] JUMP_TERM  = JCW'(JUMP_STEP_CYCLES - 1);
    localparam logic [HW-1:0]  HEIGHT_TOP = HW'(JUMP_HEIGHT);
    localparam logic [11:0]    X_INIT     = 12'(INIT_X);
    localparam logic [11:0]    Y_FLOOR    = 12'(INIT_Y);
    localparam logic [11:0]    X_LIMIT    = 12'(X_MAX);

    state_e         state_q, state_d;
    logic [11:0]    xpos_q, xpos_d;
    logic [11:0]    ypos_q, ypos_d;
    logic           airborne_q, airborne_d;
    logic           facing_q, facing_d;
    logic [MCW-1:0] move_cnt_q, move_cnt_d;
    logic [JCW-1:0] jump_cnt_q, jump_cnt_d;
    logic [HW-1:0]  height_q, height_d;
    logic           one_dir;

    assign one_dir = left ^ right;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GROUND;
            xpos_q     <= X_INIT;
            ypos_q     <= Y_FLOOR;
            airborne_q <= 1'b0;
            facing_q   <= 1'b0;
            move_cnt_q <= '0;
            jump_cnt_q <= '0;
            height_q   <= '0;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            airborne_q <= airborne_d;
            facing_q   <= facing_d;
            move_cnt_q <= move_cnt_d;
            jump_cnt_q <= jump_cnt_d;
            height_q   <= height_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        facing_d   = facing_q;
        move_cnt_d = '0;
        jump_cnt_d = jump_cnt_q;
        height_d   = height_q;

        // Horizontal: the step counter keeps running at a wall so the cadence stays even.
        if (one_dir) begin
            facing_d = left;
            if (move_cnt_q == MOVE_TERM) begin
                move_cnt_d = '0;
                if (left && (xpos_q != 12'd0)) begin
                    xpos_d = xpos_q - 12'd1;
                end else if (right && (xpos_q < X_LIMIT)) begin
                    xpos_d = xpos_q + 12'd1;
                end
            end else begin
                move_cnt_d = move_cnt_q + 1'b1;
            end
        end

        case (state_q)
            GROUND: begin
                ypos_d     = Y_FLOOR;
                height_d   = '0;
                jump_cnt_d = '0;
                if (jump) begin
                    state_d = RISE;
                end
            end
            RISE: begin
                if (jump_cnt_q == JUMP_TERM) begin
                    jump_cnt_d = '0;
                    ypos_d     = ypos_q - 12'd1;
                    height_d   = height_q + 1'b1;
                    if (height_d == HEIGHT_TOP) begin
                        state_d = FALL;
                    end
                end else begin
                    jump_cnt_d = jump_cnt_q + 1'b1;
                end
            end
            FALL: begin
                if (jump_cnt_q == JUMP_TERM) begin
                    jump_cnt_d = '0;
                    ypos_d     = ypos_q + 12'd1;
                    height_d   = height_q - 1'b1;
                    if (height_d == '0) begin
                        state_d = GROUND;
                    end
                end else begin
                    jump_cnt_d = jump_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = GROUND;
                ypos_d     = Y_FLOOR;
                height_d   = '0;
                jump_cnt_d = '0;
            end
        endcase

        if (restart) begin
            state_d    = GROUND;
            xpos_d     = X_INIT;
            ypos_d     = Y_FLOOR;
            facing_d   = 1'b0;
            move_cnt_d = '0;
            jump_cnt_d = '0;
            height_d   = '0;
        end

        airborne_d = (state_d != GROUND);
    end

    assign xpos        = xpos_q;
    assign ypos        = ypos_q;
    assign airborne    = airborne_q;
    assign facing_left = facing_q;

endmodule
